// File: rtl/sensor_sample_scheduler.sv
// ----------------------------------------------------------------------------
// sensor_sample_scheduler
//
// Shares one 8-bit ADC front-end between the temperature channel (adc_ch = 0)
// and the light channel (adc_ch = 1). On every period tick it converts the
// temperature channel, then the light channel. Each conversion uses a
// start/done handshake and has its own timeout. The two samples and their
// error flags are then offered as one record to the UART framer over a
// valid/ready handshake. A tick that arrives while a sequence is still in
// flight is dropped, and overrun_cnt counts it (saturating).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   enable       runs the period counter; low holds it at 0 (no ticks)
//   adc_start    one-cycle conversion request to the ADC front-end
//   adc_ch       channel select: 0 = temperature, 1 = light
//   adc_done     conversion complete; adc_data is valid in the same cycle
//   adc_data     conversion result
//   rec_valid    record available to the UART framer
//   rec_ready    UART framer accepts the record
//   rec_temp     captured temperature sample (8'h00 on timeout)
//   rec_light    captured light sample (8'h00 on timeout)
//   rec_err      bit0 = temperature timeout, bit1 = light timeout
//   overrun_cnt  number of dropped ticks, saturates at 8'hFF
//   busy         high in every state except IDLE
// ----------------------------------------------------------------------------
module sensor_sample_scheduler #(
    parameter int unsigned PERIOD_CYCLES  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       adc_start,
    output logic       adc_ch,
    input  logic       adc_done,
    input  logic [7:0] adc_data,
    output logic       rec_valid,
    input  logic       rec_ready,
    output logic [7:0] rec_temp,
    output logic [7:0] rec_light,
    output logic [1:0] rec_err,
    output logic [7:0] overrun_cnt,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_T,
        ST_WAIT_T,
        ST_START_L,
        ST_WAIT_L,
        ST_PRESENT
    } state_e;

    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             adc_start_q, adc_start_d;
    logic             adc_ch_q, adc_ch_d;
    logic             rec_valid_q, rec_valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       rec_temp_q, rec_temp_d;
    logic [7:0]       rec_light_q, rec_light_d;
    logic [1:0]       rec_err_q, rec_err_d;
    logic [7:0]       overrun_q, overrun_d;

    logic tick;
    logic tmo_expired;

    assign tick = enable && (period_cnt_q == PERIOD_LAST);

    // The counter is 0 in the first WAIT cycle, so it "reaches" TIMEOUT_CYCLES
    // on the cycle where it holds TIMEOUT_CYCLES-1: the WAIT state lasts at
    // most TIMEOUT_CYCLES cycles.
    assign tmo_expired = (tmo_cnt_q == TIMEOUT_LAST);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        rec_temp_d   = rec_temp_q;
        rec_light_d  = rec_light_q;
        rec_err_d    = rec_err_q;
        overrun_d    = overrun_q;
        adc_ch_d     = adc_ch_q;

        // Period counter: held at 0 while disabled, wraps after PERIOD_LAST.
        if (!enable || tick) begin
            period_cnt_d = '0;
        end else begin
            period_cnt_d = period_cnt_q + CNT_W'(1);
        end

        // A tick outside IDLE is dropped. This includes the PRESENT handshake
        // cycle: the state is still PRESENT, so the tick is not queued.
        if (tick && (state_q != ST_IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d   = ST_START_T;
                    rec_err_d = 2'b00;
                end
            end
            ST_START_T: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_T;
            end
            ST_WAIT_T: begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                // adc_done is checked first, so it wins when it lands on the
                // expiry cycle.
                if (adc_done) begin
                    rec_temp_d = adc_data;
                    state_d    = ST_START_L;
                end else if (tmo_expired) begin
                    rec_temp_d   = 8'h00;
                    rec_err_d[0] = 1'b1;
                    state_d      = ST_START_L;
                end
            end
            ST_START_L: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_L;
            end
            ST_WAIT_L: begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                if (adc_done) begin
                    rec_light_d = adc_data;
                    state_d     = ST_PRESENT;
                end else if (tmo_expired) begin
                    rec_light_d  = 8'h00;
                    rec_err_d[1] = 1'b1;
                    state_d      = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // rec_valid is high throughout PRESENT, so rec_ready alone
                // completes the transfer.
                if (rec_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered and decoded from the next state, so each one
        // lines up with the state it belongs to. adc_ch only changes when a
        // START state is entered, which keeps it stable through WAIT.
        adc_start_d = (state_d == ST_START_T) || (state_d == ST_START_L);
        if (state_d == ST_START_T) begin
            adc_ch_d = 1'b0;
        end else if (state_d == ST_START_L) begin
            adc_ch_d = 1'b1;
        end
        rec_valid_d = (state_d == ST_PRESENT);
        busy_d      = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // update together at the edge, so no flop sees another's new value early.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            period_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            adc_start_q  <= 1'b0;
            adc_ch_q     <= 1'b0;
            rec_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            rec_temp_q   <= 8'h00;
            rec_light_q  <= 8'h00;
            rec_err_q    <= 2'b00;
            overrun_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            adc_start_q  <= adc_start_d;
            adc_ch_q     <= adc_ch_d;
            rec_valid_q  <= rec_valid_d;
            busy_q       <= busy_d;
            rec_temp_q   <= rec_temp_d;
            rec_light_q  <= rec_light_d;
            rec_err_q    <= rec_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign adc_start   = adc_start_q;
    assign adc_ch      = adc_ch_q;
    assign rec_valid   = rec_valid_q;
    assign busy        = busy_q;
    assign rec_temp    = rec_temp_q;
    assign rec_light   = rec_light_q;
    assign rec_err     = rec_err_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_sensor_sample_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sensor_sample_scheduler
//
// Directed bench for sensor_sample_scheduler with PERIOD_CYCLES = 20 and
// TIMEOUT_CYCLES = 8. A small ADC model answers each adc_start after a
// per-channel delay, or never when the delay is 0. Inputs are driven and
// outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_sensor_sample_scheduler;

    localparam int PERIOD  = 20;
    localparam int TIMEOUT = 8;
    localparam int W_START = 0;
    localparam int W_VALID = 1;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       adc_start;
    logic       adc_ch;
    logic       adc_done;
    logic [7:0] adc_data;
    logic       rec_valid;
    logic       rec_ready;
    logic [7:0] rec_temp;
    logic [7:0] rec_light;
    logic [1:0] rec_err;
    logic [7:0] overrun_cnt;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // ADC model settings: a delay of d raises adc_done d cycles after the
    // adc_start cycle. A delay of 0 means the channel never answers.
    int         dly0 = 3;
    int         dly1 = 3;
    logic [7:0] d0   = 8'd25;
    logic [7:0] d1   = 8'd150;

    sensor_sample_scheduler #(
        .PERIOD_CYCLES (PERIOD),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .adc_start  (adc_start),
        .adc_ch     (adc_ch),
        .adc_done   (adc_done),
        .adc_data   (adc_data),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_temp   (rec_temp),
        .rec_light  (rec_light),
        .rec_err    (rec_err),
        .overrun_cnt(overrun_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC front-end model.
    initial begin
        int   cd;
        logic ch_pend;
        cd       = 0;
        ch_pend  = 1'b0;
        adc_done = 1'b0;
        adc_data = 8'h00;
        forever begin
            @(negedge clk);
            adc_done = 1'b0;
            if (!rst) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        adc_done = 1'b1;
                        adc_data = ch_pend ? d1 : d0;
                    end
                end
                if (adc_start) begin
                    ch_pend = adc_ch;
                    cd      = adc_ch ? dly1 : dly0;
                end
            end
        end
    end

    // Watchdog so that a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig_of(input int which);
        return (which == W_START) ? adc_start : rec_valid;
    endfunction

    // Advances at least one falling edge, then stops on the first falling edge
    // where the selected output is high. n is the number of edges waited.
    // If the budget runs out, n equals max_cyc, which the caller's check flags.
    task automatic wait_for(input int which, input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig_of(which) && (n < max_cyc));
    endtask

    initial begin
        int n;
        int bad;
        int starts;

        rst       = 1'b0;
        enable    = 1'b0;
        rec_ready = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- reset state ----------------
        check("rst_adc_start", adc_start, 0);
        check("rst_adc_ch", adc_ch, 0);
        check("rst_rec_valid", rec_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rec_temp", rec_temp, 0);
        check("rst_rec_light", rec_light, 0);
        check("rst_rec_err", rec_err, 0);
        check("rst_overrun", overrun_cnt, 0);

        // ---------------- normal records, rec_ready = 1 ----------------
        rst       = 1'b1;
        enable    = 1'b1;
        rec_ready = 1'b1;
        wait_for(W_START, 40, n);
        check("first_tick_latency", n, PERIOD);
        check("start_t_ch", adc_ch, 0);
        check("start_t_busy", busy, 1);
        @(negedge clk);
        check("start_pulse_width", adc_start, 0);
        check("wait_t_ch_held", adc_ch, 0);
        wait_for(W_START, 20, n);
        check("temp_to_light_gap", n, 3);
        check("start_l_ch", adc_ch, 1);
        wait_for(W_VALID, 20, n);
        check("light_to_present_gap", n, 4);
        check("rec1_temp", rec_temp, 25);
        check("rec1_light", rec_light, 150);
        check("rec1_err", rec_err, 0);
        @(negedge clk);
        check("rec1_accepted", rec_valid, 0);
        check("rec1_idle", busy, 0);
        wait_for(W_VALID, 40, n);
        check("record_period", n, PERIOD - 1);
        check("rec2_temp", rec_temp, 25);
        check("rec2_light", rec_light, 150);
        @(negedge clk);
        check("rec2_accepted", rec_valid, 0);

        // ---------------- back-pressure: rec_ready low for 40 cycles ----------------
        rec_ready = 1'b0;
        wait_for(W_VALID, 40, n);
        check("rec3_arrival", n, PERIOD - 1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (!(rec_valid === 1'b1 && rec_temp === 8'd25 && rec_light === 8'd150 && rec_err === 2'b00))
                bad++;
            @(negedge clk);
        end
        check("stall_stable_cycles_bad", bad, 0);
        check("stall_overrun", overrun_cnt, 2);
        rec_ready = 1'b1;
        @(negedge clk);
        check("stall_accept_1cyc", rec_valid, 0);

        // ---------------- temperature timeout, light = 240 ----------------
        dly0 = 0;
        dly1 = 3;
        d1   = 8'd240;
        wait_for(W_START, 40, n);
        check("tmo_t_start_latency", n, 11);
        wait_for(W_START, 20, n);
        check("tmo_t_wait_len", n, TIMEOUT + 1);
        wait_for(W_VALID, 20, n);
        check("tmo_t_present_gap", n, 4);
        check("tmo_t_temp", rec_temp, 0);
        check("tmo_t_light", rec_light, 240);
        check("tmo_t_err", rec_err, 2'b01);

        // ---------------- adc_done on the light timeout-expiry cycle ----------------
        dly0 = 3;
        d0   = 8'd25;
        dly1 = TIMEOUT;
        d1   = 8'd10;
        wait_for(W_START, 40, n);
        check("edge_start_latency", n, 7);
        check("edge_err_cleared_on_tick", rec_err, 0);
        wait_for(W_START, 20, n);
        check("edge_temp_to_light_gap", n, 4);
        wait_for(W_VALID, 20, n);
        check("edge_present_gap", n, TIMEOUT + 1);
        check("edge_temp", rec_temp, 25);
        check("edge_light", rec_light, 10);
        check("edge_err", rec_err, 0);

        // ---------------- reset in the middle of WAIT_L ----------------
        dly1 = 3;
        d1   = 8'd150;
        wait_for(W_START, 40, n);
        wait_for(W_START, 20, n);
        check("rst_seq_light_start", adc_ch, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_adc_ch", adc_ch, 0);
        check("midrst_rec_valid", rec_valid, 0);
        check("midrst_rec_temp", rec_temp, 0);
        check("midrst_overrun", overrun_cnt, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_for(W_START, 40, n);
        check("postrst_tick_latency", n, PERIOD);
        check("postrst_no_record_yet", rec_valid, 0);
        wait_for(W_VALID, 20, n);
        check("postrst_present_gap", n, 8);
        check("postrst_temp", rec_temp, 25);
        check("postrst_light", rec_light, 150);
        check("postrst_err", rec_err, 0);

        // ---------------- enable dropped during WAIT_T ----------------
        wait_for(W_START, 40, n);
        check("en_seq_start", n, 12);
        @(negedge clk);
        enable = 1'b0;
        wait_for(W_VALID, 20, n);
        check("en_off_present_gap", n, 7);
        check("en_off_temp", rec_temp, 25);
        check("en_off_light", rec_light, 150);
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (adc_start === 1'b1)
                starts++;
        end
        check("en_off_no_start", starts, 0);
        check("en_off_idle", busy, 0);
        enable = 1'b1;
        wait_for(W_START, 40, n);
        check("en_on_first_tick", n, PERIOD);
        check("final_overrun", overrun_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
